mips_fetch_unit: RTL and testbench

Instruction fetch front-end for the 5-stage MIPS32 pipeline. It sits directly upstream of decode and replaces the direct Mem[PC] read in IF.
- Issues word-addressed requests to an instruction memory port with a request/grant handshake and in-order, variable-latency responses.
- Buffers returned words in a small prefetch FIFO and presents {IR, NPC} to ID with a valid/ready handshake.
- Honours branch redirects from EX/MEM and the halt signal.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/mips_fetch_fifo.sv | 68 ++++++
 rtl/mips_fetch_unit.sv | 125 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS32 pipeline: opcode constants,
// instruction type codes, datapath word width and the NOP encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5,
        NOP    = 3'd6
    } instr_type_e;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_fifo.sv
// -----------------------------------------------------------------------------
// mips_fetch_fifo
// Show-ahead prefetch FIFO, DEPTH entries of {instruction, npc}.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush_i      clear all entries (wins over push/pop)
//   push_i       write data_i at tail (caller guarantees not full)
//   data_i       {ir, npc}
//   pop_i        drop head entry (caller guarantees not empty)
//   head_o       current head entry, valid when !empty_o
//   empty_o      FIFO holds no entries
//   count_o      number of entries held
// -----------------------------------------------------------------------------
module mips_fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [2*WORD_W-1:0]          data_i,
    input  logic                         pop_i,
    output logic [2*WORD_W-1:0]          head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [2*WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; consumers qualify the head with empty_o.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// Instruction fetch front-end: issues word requests to instruction memory,
// buffers in-order responses in a prefetch FIFO and hands {IR, NPC} to decode.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   redirect, redirect_pc  taken-branch pulse and target word address
//   halt                   stop issuing fetches
//   imem_req/addr/gnt      request handshake to instruction memory
//   imem_rvalid/rdata      in-order response, one per granted request
//   id_valid/ir/npc        instruction and fetch address + 1 to decode
//   id_ready               decode accepts (low = stall)
// -----------------------------------------------------------------------------
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 10,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_ir,
    output logic [WORD_W-1:0] id_npc,
    input  logic              id_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [OUT_W-1:0]    drop_q, drop_d;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic [2*WORD_W-1:0] fifo_head;
    logic [31:0]         occupancy;
    logic                rvalid_ok;
    logic                grant;
    logic                push;
    logic                pop;

    // A response with nothing outstanding is a protocol violation; ignore it.
    assign rvalid_ok = imem_rvalid && (out_q != '0);

    // Credit: buffered words plus in-flight requests never exceed FIFO depth,
    // so every response is guaranteed a free slot.
    assign occupancy = 32'(fifo_count) + 32'(out_q);
    assign imem_req  = !rst && !halt && !redirect
                       && (occupancy < 32'(DEPTH))
                       && (32'(out_q) < 32'(MAX_OUT));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    assign id_valid = !fifo_empty && !redirect;
    assign pop      = id_valid && id_ready;
    assign push     = rvalid_ok && !redirect && (drop_q == '0);
    assign id_ir    = id_valid ? fifo_head[2*WORD_W-1:WORD_W] : '0;
    assign id_npc   = id_valid ? fifo_head[WORD_W-1:0]        : '0;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q;
        drop_d    = drop_q;
        if (redirect) begin
            // Every request still in flight belongs to the old path.
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            out_d     = out_q - OUT_W'(rvalid_ok);
            drop_d    = out_q - OUT_W'(rvalid_ok);
        end else begin
            if (grant) pc_d = pc_q + ADDR_W'(1);
            out_d = out_q + OUT_W'(grant) - OUT_W'(rvalid_ok);
            if (rvalid_ok) begin
                if (drop_q != '0) drop_d    = drop_q - OUT_W'(1);
                else              resp_pc_d = resp_pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end

    mips_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  ({imem_rdata, 32'(resp_pc_q) + 32'd1}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (out_q == '0)));

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          id_valid;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic          id_ready = 1'b0;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .DEPTH(4), .ADDR_W(AW), .MAX_OUT(2), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ir(id_ir), .id_npc(id_npc), .id_ready(id_ready)
    );

    typedef struct { int addr; int due; } req_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    req_t        pend[$];
    int          grant_log[$];
    int          exp_addr = 0;
    int          grants = 0;
    int          deliv = 0;
    int          first_grant = -1;
    int          first_valid = -1;
    logic [31:0] first_ir = '0;
    logic [31:0] first_npc = '0;
    logic [31:0] last_ir = '0;
    logic [31:0] last_npc = '0;

    function automatic logic [31:0] memw(int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are observed at
    // the falling edge, the reference stream is advanced.
    task automatic tick();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        if (imem_req && imem_gnt) begin
            pend.push_back('{addr: int'(imem_addr), due: cyc + lat});
            grant_log.push_back(int'(imem_addr));
            grants++;
            if (first_grant < 0) first_grant = cyc;
        end
        if (halt) chk("halt_no_req", 32'(imem_req), 32'd0);
        if (id_valid && id_ready) begin
            chk("stream_ir", id_ir, memw(exp_addr));
            chk("stream_npc", id_npc, 32'(exp_addr + 1));
            exp_addr = (exp_addr + 1) % 1024;
            deliv++;
            last_ir  = id_ir;
            last_npc = id_npc;
            if (first_valid < 0) begin
                first_valid = cyc;
                first_ir    = id_ir;
                first_npc   = id_npc;
            end
        end
        if (redirect) begin
            chk("redir_no_valid", 32'(id_valid), 32'd0);
            chk("redir_no_req", 32'(imem_req), 32'd0);
            exp_addr = int'(redirect_pc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_ir", id_ir, 32'd0);
        chk("rst_npc", id_npc, 32'd0);
        repeat (4) tick();
        rst = 1'b0;
        pend.delete();
        grant_log.delete();
        exp_addr    = 0;
        grants      = 0;
        deliv       = 0;
        first_grant = -1;
        first_valid = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int g0;
        int gl;
        logic [AW-1:0] a0;

        #2;
        do_reset();

        // Streaming, 1-cycle memory
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b1;
        repeat (12) tick();
        chk("t1_latency", 32'(first_valid - first_grant), 32'd2);
        chk("t1_first_ir", first_ir, 32'h1000_0000);
        chk("t1_first_npc", first_npc, 32'd1);
        chk("t1_rate", 32'(deliv), 32'd10);

        // Decode stall from empty
        do_reset();
        id_ready = 1'b0;
        repeat (12) tick();
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_req_off", 32'(imem_req), 32'd0);
        chk("t2_hold_valid", 32'(id_valid), 32'd1);
        chk("t2_hold_ir", id_ir, 32'h1000_0000);
        id_ready = 1'b1;
        d0 = deliv;
        repeat (4) tick();
        chk("t2_burst", 32'(deliv - d0), 32'd4);
        chk("t2_burst_npc", last_npc, 32'd4);
        repeat (6) tick();

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        n = 0;
        while (pend.size() != 2 && n < 20) begin tick(); n++; end
        chk("t3_two_out", 32'(pend.size()), 32'd2);
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        d0 = deliv; n = 0;
        while (deliv == d0 && n < 30) begin tick(); n++; end
        chk("t3_ir", last_ir, memw(32'h40));
        chk("t3_npc", last_npc, 32'h41);

        // Grant withheld, then halt
        imem_gnt = 1'b0; id_ready = 1'b0;
        a0 = imem_addr;
        repeat (3) begin
            tick();
            chk("t4_addr_stable", 32'(imem_addr), 32'(a0));
        end
        imem_gnt = 1'b1; id_ready = 1'b1; halt = 1'b1;
        #1;
        chk("t4_req_drop", 32'(imem_req), 32'd0);
        d0 = deliv;
        repeat (8) tick();
        chk("t4_drained", 32'(deliv > d0), 32'd1);
        chk("t4_none_pending", 32'(pend.size()), 32'd0);
        halt = 1'b0;
        g0 = grants;
        tick();
        chk("t4_resume_grant", 32'(grants), 32'(g0 + 1));
        chk("t4_resume_addr", 32'(grant_log[grant_log.size()-1]), last_npc % 1024);

        // Redirect to the last word of memory
        lat = 1;
        repeat (4) tick();
        redirect = 1'b1; redirect_pc = 10'h3FF;
        gl = grant_log.size();
        tick();
        redirect = 1'b0;
        d0 = deliv; n = 0;
        while (deliv == d0 && n < 20) begin tick(); n++; end
        chk("t5_ir", last_ir, 32'h1000_03FF);
        chk("t5_npc", last_npc, 32'h400);
        chk("t5_two_grants", 32'(grant_log.size() >= gl + 2), 32'd1);
        if (grant_log.size() >= gl + 2) begin
            chk("t5_addr_top", 32'(grant_log[gl]), 32'h3FF);
            chk("t5_addr_wrap", 32'(grant_log[gl+1]), 32'h000);
        end

        // Reset with two requests in flight
        lat = 3;
        n = 0;
        while (pend.size() != 2 && n < 20) begin tick(); n++; end
        chk("t6_two_out", 32'(pend.size()), 32'd2);
        do_reset();
        tick();
        chk("t6_first_grant", 32'(grant_log.size() >= 1), 32'd1);
        if (grant_log.size() >= 1) chk("t6_first_addr", 32'(grant_log[0]), 32'd0);
        repeat (8) tick();

        // Randomized traffic against the stream model
        for (int seg = 0; seg < 4; seg++) begin
            lat = $urandom_range(1, 3);
            repeat (100) begin
                imem_gnt    = ($urandom % 5) != 0;
                id_ready    = ($urandom % 4) != 0;
                halt        = ($urandom % 10) == 0;
                redirect    = ($urandom % 25) == 0;
                redirect_pc = AW'($urandom);
                tick();
            end
            redirect = 1'b0; halt = 1'b0;
            imem_gnt = 1'b0; id_ready = 1'b1;
            repeat (10) tick();
            chk("rand_drained", 32'(pend.size()), 32'd0);
            imem_gnt = 1'b1;
        end
        chk("rand_delivered", 32'(deliv > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
